// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM encodings and parameter range check for the serial adder
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational full adder built from two half-adder stages
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_hs1_s;
    logic w_hs1_c;
    logic w_hs2_c;

    assign w_hs1_s = i_a ^ i_b;
    assign w_hs1_c = i_a & i_b;
    assign o_s     = w_hs1_s ^ i_cin;
    assign w_hs2_c = w_hs1_s & i_cin;
    assign o_cout  = w_hs1_c | w_hs2_c;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with valid/ready operand and result handshakes
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_adder: WIDTH out of range");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic w_s;
    logic w_cout;
    logic w_accept;
    logic w_last;

    serial_fa_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == CNT_LAST);

    // The carry flop doubles as carry_out, so it is final exactly when DONE is entered.
    assign sum_out   = r_sum;
    assign carry_out = r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    int checks;
    int failures;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand pair, checks the exact latency, then the result and the drain.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_carry,
                           input bit poke_busy, input int hold_cycles);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (poke_busy) begin
            a_in = 8'h77;
            b_in = 8'h77;
        end else begin
            in_valid = 1'b0;
        end
        check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        check({tag, "_no_early_valid"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum_out, exp_sum);
        check({tag, "_carry"}, carry_out, exp_carry);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_sum"}, sum_out, exp_sum);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, out_valid, 1'b0);
        check({tag, "_drain_ready"}, in_ready, 1'b1);
        check({tag, "_idle_sum_held"}, sum_out, exp_sum);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum_out, 8'h00);
        check("rst_carry", carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_in_ready", in_ready, 1'b1);
            check("post_rst_out_valid", out_valid, 1'b0);
        end

        run_add("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 0);
        run_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        run_add("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 0);
        run_add("bp_12_34", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 5);
        run_add("busy_01_02", 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 0);

        // Abort mid-SHIFT with an asynchronous reset between clock edges.
        @(negedge clk);
        a_in     = 8'hF0;
        b_in     = 8'h0F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum", sum_out, 8'h00);
        check("abort_carry", carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", out_valid, 1'b0);
        end
        run_add("after_abort_80_80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
